// File: rtl/load_store_unit.sv
// Load/store unit: accepts one memory request at a time, drives the memory pins,
// waits out the read latency and returns a tagged response.
module load_store_unit #(
  parameter int DATA_W       = 19,
  parameter int MEM_DEPTH    = 1024,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [DATA_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [3:0]        req_rd,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [3:0]        rsp_rd,
  output logic              rsp_write,
  output logic              rsp_fault,
  output logic [DATA_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic              busy
);

  if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
    $error("load_store_unit: READ_LATENCY must be in 1..4");
  end

  typedef enum logic [2:0] {IDLE, WRITE, READ, WAIT, RESP} state_t;

  localparam logic [DATA_W:0] DEPTH    = (DATA_W+1)'(MEM_DEPTH);
  localparam logic [2:0]      CNT_INIT = 3'(READ_LATENCY - 1);

  state_t            state, state_next;
  logic [DATA_W-1:0] addr_q, wdata_q, data_q;
  logic [3:0]        rd_q;
  logic              write_q, fault_q;
  logic [2:0]        cnt;
  logic              addr_fault;

  assign addr_fault = ({1'b0, req_addr} >= DEPTH);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (addr_fault)     state_next = RESP;
          else if (req_write) state_next = WRITE;
          else                state_next = READ;
        end
      end
      WRITE:   state_next = RESP;
      READ:    state_next = WAIT;
      WAIT:    if (cnt == 3'd0) state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == IDLE);
    busy      = (state != IDLE);
    mem_write = (state == WRITE);
    mem_read  = (state == READ);
    rsp_valid = (state == RESP);
  end

  // Request latch, wait counter and response data capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= '0;
      write_q <= 1'b0;
      fault_q <= 1'b0;
      data_q  <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            rd_q    <= req_rd;
            write_q <= req_write;
            fault_q <= addr_fault;
            data_q  <= '0;
          end
        end
        READ: cnt <= CNT_INIT;
        WAIT: begin
          if (cnt == 3'd0) data_q <= mem_read_data;
          else             cnt    <= cnt - 3'd1;
        end
        default: ;
      endcase
    end
  end

  assign mem_address    = addr_q;
  assign mem_write_data = wdata_q;
  assign rsp_data       = data_q;
  assign rsp_rd         = rd_q;
  assign rsp_write      = write_q;
  assign rsp_fault      = fault_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: two instances (read latency 1 and 4), each with its own
// emulated memory, checked against a transaction-level model of expected responses.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_write [2];
  logic [18:0] req_addr [2];
  logic [18:0] req_wdata [2];
  logic [3:0]  req_rd [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [18:0] rsp_data [2];
  logic [3:0]  rsp_rd [2];
  logic        rsp_write [2];
  logic        rsp_fault [2];
  logic [18:0] mem_address [2];
  logic [18:0] mem_write_data [2];
  logic        mem_write [2];
  logic        mem_read [2];
  logic [18:0] mem_read_data [2];
  logic        busy [2];

  int checks = 0;
  int errors = 0;

  logic [18:0] ram [2][1024];
  logic [18:0] pipe [2][4];
  logic [18:0] model_mem [2][1024];
  bit          model_known [2][1024];

  always #5 clk = ~clk;

  load_store_unit #(.DATA_W(19), .MEM_DEPTH(1024), .READ_LATENCY(1)) dut0 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_rd(req_rd[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_data(rsp_data[0]),
    .rsp_rd(rsp_rd[0]), .rsp_write(rsp_write[0]), .rsp_fault(rsp_fault[0]),
    .mem_address(mem_address[0]), .mem_write_data(mem_write_data[0]),
    .mem_write(mem_write[0]), .mem_read(mem_read[0]),
    .mem_read_data(mem_read_data[0]), .busy(busy[0])
  );

  load_store_unit #(.DATA_W(19), .MEM_DEPTH(1024), .READ_LATENCY(4)) dut1 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_rd(req_rd[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_data(rsp_data[1]),
    .rsp_rd(rsp_rd[1]), .rsp_write(rsp_write[1]), .rsp_fault(rsp_fault[1]),
    .mem_address(mem_address[1]), .mem_write_data(mem_write_data[1]),
    .mem_write(mem_write[1]), .mem_read(mem_read[1]),
    .mem_read_data(mem_read_data[1]), .busy(busy[1])
  );

  // Emulated MemoryInterface: read data appears latency cycles after the sampling edge,
  // and is random junk at every other time so mistimed captures are visible.
  always @(posedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (mem_write[u] && mem_address[u] < 19'd1024)
        ram[u][mem_address[u][9:0]] <= mem_write_data[u];
      for (int i = 3; i > 0; i--) pipe[u][i] <= pipe[u][i-1];
      if (mem_read[u] && mem_address[u] < 19'd1024)
        pipe[u][0] <= ram[u][mem_address[u][9:0]];
      else
        pipe[u][0] <= 19'($urandom);
    end
  end

  assign mem_read_data[0] = pipe[0][0];
  assign mem_read_data[1] = pipe[1][3];

  function automatic int lat_of(input int u);
    return (u == 0) ? 1 : 4;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkResetValues(input int u);
    checkOutput("rst_req_ready", req_ready[u], 1);
    checkOutput("rst_busy", busy[u], 0);
    checkOutput("rst_rsp_valid", rsp_valid[u], 0);
    checkOutput("rst_rsp_data", rsp_data[u], 0);
    checkOutput("rst_rsp_rd", rsp_rd[u], 0);
    checkOutput("rst_rsp_write", rsp_write[u], 0);
    checkOutput("rst_rsp_fault", rsp_fault[u], 0);
    checkOutput("rst_mem_address", mem_address[u], 0);
    checkOutput("rst_mem_write_data", mem_write_data[u], 0);
    checkOutput("rst_mem_write", mem_write[u], 0);
    checkOutput("rst_mem_read", mem_read[u], 0);
  endtask

  // One full transaction on unit u, starting and ending at a negedge in IDLE.
  task automatic applyStimulus(input int u, input bit w, input int addr, input int wdata,
                               input int rd, input bit f, input int data, input int lat,
                               input int hold, input bit poke);
    int cyc, nwr, nrd;
    checkOutput("idle_req_ready", req_ready[u], 1);
    req_write[u] = w;
    req_addr[u]  = 19'(addr);
    req_wdata[u] = 19'(wdata);
    req_rd[u]    = 4'(rd);
    req_valid[u] = 1'b1;
    step();
    req_valid[u] = 1'b0;
    req_write[u] = 1'($urandom);
    req_addr[u]  = 19'($urandom);
    req_wdata[u] = 19'($urandom);
    req_rd[u]    = 4'($urandom);
    cyc = 1;
    nwr = 0;
    nrd = 0;
    while (!rsp_valid[u] && cyc < 40) begin
      if (cyc == 1) begin
        checkOutput("c1_mem_write", mem_write[u], (w && !f) ? 1 : 0);
        checkOutput("c1_mem_read", mem_read[u], (!w && !f) ? 1 : 0);
      end
      if (mem_write[u]) begin
        nwr++;
        checkOutput("wr_address", mem_address[u], addr);
        checkOutput("wr_data", mem_write_data[u], wdata);
      end
      if (mem_read[u]) begin
        nrd++;
        checkOutput("rd_address", mem_address[u], addr);
      end
      checkOutput("busy_inflight", busy[u], 1);
      step();
      cyc++;
    end
    checkOutput("rsp_arrived", rsp_valid[u], 1);
    if (!rsp_valid[u]) return;
    checkOutput("rsp_latency", cyc, lat);
    checkOutput("rsp_data", rsp_data[u], data);
    checkOutput("rsp_rd", rsp_rd[u], rd);
    checkOutput("rsp_write", rsp_write[u], w);
    checkOutput("rsp_fault", rsp_fault[u], f);
    checkOutput("write_pulses", nwr, (w && !f) ? 1 : 0);
    checkOutput("read_pulses", nrd, (!w && !f) ? 1 : 0);
    checkOutput("resp_req_ready", req_ready[u], 0);
    for (int i = 0; i < hold; i++) begin
      if (poke) begin
        req_valid[u] = 1'b1;
        req_write[u] = 1'b1;
        req_addr[u]  = 19'($urandom_range(0, 1023));
      end
      step();
      checkOutput("hold_rsp_valid", rsp_valid[u], 1);
      checkOutput("hold_req_ready", req_ready[u], 0);
      checkOutput("hold_rsp_data", rsp_data[u], data);
      checkOutput("hold_rsp_rd", rsp_rd[u], rd);
      checkOutput("hold_rsp_fault", rsp_fault[u], f);
      checkOutput("hold_mem_pulse", {mem_write[u], mem_read[u]}, 0);
    end
    req_valid[u] = 1'b0;
    rsp_ready[u] = 1'b1;
    step();
    rsp_ready[u] = 1'b0;
    checkOutput("post_req_ready", req_ready[u], 1);
    checkOutput("post_busy", busy[u], 0);
    checkOutput("post_rsp_valid", rsp_valid[u], 0);
    if (w && !f) begin
      model_mem[u][addr] = 19'(wdata);
      model_known[u][addr] = 1'b1;
    end
  endtask

  typedef struct {
    int unit; bit w; int addr; int wdata; int rd;
    bit f; int data; int lat; int hold; bit poke;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int u, addr, wdata, rd, lat, sel;
    bit w, f;
    vecs[0] = '{0, 1, 0,       42,  1, 0, 0,  2, 0, 0};
    vecs[1] = '{0, 0, 0,       0,   3, 0, 42, 3, 0, 0};
    vecs[2] = '{1, 1, 0,       42,  1, 0, 0,  2, 0, 0};
    vecs[3] = '{1, 0, 0,       0,   3, 0, 42, 6, 0, 0};
    vecs[4] = '{0, 0, 1024,    0,   2, 1, 0,  1, 0, 0};
    vecs[5] = '{0, 1, 1023,    7,   4, 0, 0,  2, 0, 0};
    vecs[6] = '{0, 0, 1023,    0,   5, 0, 7,  3, 5, 1};
    vecs[7] = '{0, 1, 9,       100, 6, 0, 0,  2, 0, 0};
    vecs[8] = '{1, 1, 1024,    55,  7, 1, 0,  1, 2, 0};
    vecs[9] = '{1, 0, 'h7FFFF, 0,   8, 1, 0,  1, 0, 0};

    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0; req_write[i] = 1'b0; req_addr[i] = '0;
      req_wdata[i] = '0;   req_rd[i] = '0;      rsp_ready[i] = 1'b0;
    end
    reset = 1'b1;
    #3;
    checkResetValues(0);
    checkResetValues(1);
    @(negedge clk);
    reset = 1'b0;
    step();

    for (int i = 0; i < 10; i++)
      applyStimulus(vecs[i].unit, vecs[i].w, vecs[i].addr, vecs[i].wdata, vecs[i].rd,
                    vecs[i].f, vecs[i].data, vecs[i].lat, vecs[i].hold, vecs[i].poke);

    // Asynchronous reset in the middle of a latency-4 load (unit 1 in WAIT).
    req_write[1] = 1'b0; req_addr[1] = 19'd0; req_rd[1] = 4'd9; req_valid[1] = 1'b1;
    step();
    req_valid[1] = 1'b0;
    step();
    step();
    checkOutput("midload_busy", busy[1], 1);
    #2;
    reset = 1'b1;
    #1;
    checkResetValues(0);
    checkResetValues(1);
    @(negedge clk);
    step();
    checkOutput("in_reset_req_ready", req_ready[1], 1);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      checkOutput("aborted_rsp_valid", rsp_valid[1], 0);
      checkOutput("aborted_mem_read", mem_read[1], 0);
    end
    applyStimulus(1, 1, 5, 321, 10, 0, 0, 2, 0, 0);
    applyStimulus(1, 0, 5, 0, 11, 0, 321, 6, 1, 0);

    // Random transactions checked against the transaction-level model.
    for (int n = 0; n < 60; n++) begin
      u = $urandom_range(0, 1);
      sel = $urandom_range(0, 9);
      if (sel < 6)      addr = $urandom_range(0, 15);
      else if (sel < 8) addr = $urandom_range(1020, 1027);
      else              addr = int'(19'($urandom));
      w = 1'($urandom);
      f = (addr >= 1024);
      if (!w && !f && !model_known[u][addr]) w = 1'b1;
      wdata = int'(19'($urandom));
      rd = $urandom_range(0, 15);
      lat = f ? 1 : (w ? 2 : 2 + lat_of(u));
      applyStimulus(u, w, addr, wdata, rd, f, (f || w) ? 0 : int'(model_mem[u][addr]),
                    lat, $urandom_range(0, 3), 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Initiator-side memory access unit for the 19-bit CPU. It sits between the execute stage and `MemoryInterface`. It accepts one load or store request at a time over a valid/ready handshake and drives `MemoryInterface`'s `address`/`write_data`/`mem_write`/`mem_read` pins. It waits out the memory read latency and returns the result (load data or store acknowledge) over a second valid/ready handshake tagged with the destination register.

## Interface
Parameters:
- `DATA_W`, 19, data and address width
- `MEM_DEPTH`, 1024, number of valid words; addresses >= MEM_DEPTH fault without touching memory
- `READ_LATENCY`, 1, cycles from the edge sampling `mem_read` to the cycle `mem_read_data` is valid; legal 1..4

Ports:
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-high
- `req_valid`  in  1  request present
- `req_ready`  out  1  unit can accept a request
- `req_write`  in  1  1 = store, 0 = load
- `req_addr`  in  19  word address
- `req_wdata`  in  19  store data
- `req_rd`  in  4  destination register tag
- `rsp_valid`  out  1  response present
- `rsp_ready`  in  1  consumer accepts response
- `rsp_data`  out  19  load data; 0 for stores and faults
- `rsp_rd`  out  4  echoed `req_rd`
- `rsp_write`  out  1  echoed `req_write`
- `rsp_fault`  out  1  address out of range
- `mem_address`  out  19  to MemoryInterface `address`
- `mem_write_data`  out  19  to MemoryInterface `write_data`
- `mem_write`  out  1  to MemoryInterface `mem_write`
- `mem_read`  out  1  to MemoryInterface `mem_read`
- `mem_read_data`  in  19  from MemoryInterface `read_data`
- `busy`  out  1  state != IDLE

## Operation
- FSM states: IDLE, WRITE, READ, WAIT, RESP.
- IDLE: `req_ready`=1.
  - When `req_valid`, latch addr, wdata, rd and write at the edge.
  - If addr >= MEM_DEPTH, go to RESP with fault=1 and data=0.
  - Else if write, go to WRITE; else go to READ.
- WRITE: `mem_write`=1 for exactly one cycle, with `mem_address`/`mem_write_data` taken from the latch. Next state is RESP with data=0.
- READ: `mem_read`=1 for exactly one cycle. Load the 3-bit wait counter with READ_LATENCY-1. Next state is WAIT.
- WAIT: decrement the counter each cycle.
  - When the counter is 0, capture `mem_read_data` into `rsp_data` at that edge and go to RESP.
  - The unit spends exactly READ_LATENCY cycles in WAIT.
- RESP: `rsp_valid`=1.
  - `rsp_data`, `rsp_rd`, `rsp_write` and `rsp_fault` stay stable until `rsp_valid && rsp_ready`; then go to IDLE.
- `req_ready`=0 in every state except IDLE. `req_valid` outside IDLE is ignored, not queued.
- `mem_address`/`mem_write_data` hold their last latched value between accesses. `mem_write` and `mem_read` are never both 1.
- Faulting requests never assert `mem_read` or `mem_write`.
- Out-of-range READ_LATENCY is an elaboration error.

## Timing
- Reset values: `req_ready`=1, `busy`=0. All other outputs are 0, including `rsp_*`, `mem_*`, counter and latches.
- Reset is asynchronous and takes effect mid-operation: state goes to IDLE, and `mem_read`/`mem_write`/`rsp_valid` drop immediately. An in-flight request is discarded with no response.
- Cycle numbering: cycle 0 is the IDLE cycle whose edge accepts the request.
- Store: WRITE in cycle 1, first `rsp_valid` in cycle 2.
- Load: READ in cycle 1, WAIT in cycles 2..1+READ_LATENCY, first `rsp_valid` in cycle 2+READ_LATENCY.
- Fault: first `rsp_valid` in cycle 1.
- Response handshake completing in cycle N: IDLE in cycle N+1, next accept no earlier than the N+1 edge.
- Best-case throughput: store every 3 cycles, load every 3+READ_LATENCY cycles.
- All outputs are registered or decoded from state only; there is no combinational path from `req_*`/`rsp_ready` to any output.

## Test plan
- Reset: assert `reset` mid-cycle.
  - Required: all outputs at reset values immediately.
  - Required: `req_ready`=1 while and after reset.
- Store: addr 0, wdata 42, rd 1, `rsp_ready`=1.
  - Required: cycle 1 `mem_write`=1, `mem_address`=0, `mem_write_data`=42.
  - Required: cycle 2 `rsp_valid`=1, `rsp_write`=1, `rsp_fault`=0, `rsp_data`=0, `rsp_rd`=1.
- Load after store: READ_LATENCY=1, model returning 42, addr 0, rd 3.
  - Required: cycle 1 `mem_read`=1.
  - Required: cycle 3 `rsp_valid`=1, `rsp_data`=42, `rsp_rd`=3.
  - Repeat with READ_LATENCY=4: `rsp_valid` in cycle 6.
- Backpressure: hold `rsp_ready`=0 for 5 cycles while driving a second `req_valid`.
  - Required: `rsp_*` stable, `req_ready`=0, second request not accepted.
  - Release: IDLE on the next cycle, second request accepted after that.
- Fault: load at addr 1024 (MEM_DEPTH=1024).
  - Required: no `mem_read`/`mem_write` pulse.
  - Required: cycle 1 `rsp_valid`=1, `rsp_fault`=1, `rsp_data`=0.
  - Also cover addr 1023: normal access.
- Reset mid-load: READ_LATENCY=4, assert `reset` during WAIT.
  - Required: `mem_read`=0 and `rsp_valid` never asserted for that request.
  - Required: a following store to addr 5 completes normally per the store timing.
